sound_sdr_arbiter: RTL
======================

# sound_sdr_arbiter

Shares one SDRAM channel between the sound CPU port (16-bit read/write, byte enables) and the GA20 sample-fetch port (64-bit read). It sits between the sound subsystem and the SDRAM controller. Each side keeps its own toggle handshake, so the subsystem needs only one controller channel. Requests are arbitrated, latched, issued one at a time, and each completion is returned to its requester.

## Interface
Parameters:
- CPU_PRIO, 0: 0 = round-robin between pending requesters; 1 = CPU wins every tie.

Ports:
- clk_sys  in  1  system clock, 40 MHz.
- reset  in  1  reset, asynchronous, active-high.
- cpu_addr  in  25  CPU byte address into SDRAM.
- cpu_din  in  16  CPU write data.
- cpu_wr_sel  in  2  byte write enables; 00 = read.
- cpu_req  in  1  CPU request toggle.
- cpu_ack  out  1  CPU acknowledge toggle.
- cpu_dout  out  16  CPU read data.
- smp_addr  in  25  sample ROM byte address.
- smp_req  in  1  sample request toggle.
- smp_ack  out  1  sample acknowledge toggle.
- smp_data  out  64  sample read data.
- sdr_addr  out  25  address to SDRAM controller.
- sdr_din  out  16  write data to controller.
- sdr_wr_sel  out  2  byte enables to controller; 00 = read.
- sdr_req  out  1  request toggle to controller.
- sdr_ack  in  1  controller acknowledge toggle.
- sdr_dout  in  64  controller read data (one 64-bit word).
- busy  out  1  high while a transaction is in flight.

## Operation
- Handshake: a port has a request pending when req != ack. Completion is signalled by toggling ack so that it equals req. Requesters must not toggle again while pending; if they do, behaviour is undefined and not checked.
- FSM states:
  - IDLE → ISSUE when any request is pending.
  - ISSUE → WAIT after one cycle.
  - WAIT → IDLE when sdr_ack == sdr_req.
- IDLE, grant selection:
  - Only one pending: grant it.
  - Both pending, CPU_PRIO=1: grant CPU.
  - Both pending, CPU_PRIO=0: grant the port not granted last.
  - last_gnt resets to SMP, so the CPU wins the first tie.
- IDLE, on grant: latch the granted address, data and wr_sel. Sample grants force sdr_wr_sel=00 and sdr_din=0. Later changes on the requester inputs do not affect the transaction in flight.
- ISSUE: drive the latched values onto sdr_addr, sdr_din and sdr_wr_sel, and toggle sdr_req. Update last_gnt.
- WAIT, on sdr_ack == sdr_req:
  - CPU grant, read: cpu_dout = sdr_dout[16*addr[2:1] +: 16].
  - CPU grant, write: cpu_dout holds its previous value.
  - CPU grant: toggle cpu_ack on the same edge.
  - Sample grant: smp_data = sdr_dout; toggle smp_ack on the same edge.
- sdr_addr is passed through unmodified; the controller ignores bits [2:0] on reads.
- busy = (state != IDLE).

## Timing
- All outputs are registered.
- Reset value of every output, and of all internal toggles/registers, is 0. State resets to IDLE and last_gnt to SMP.
- Request toggled at edge t: IDLE sees it in cycle t+1, and sdr_req toggles at edge t+2.
- Controller acks at edge k: requester ack and data update at edge k+1. Data is valid no later than the ack toggle, in the same cycle.
- Overhead: 2 cycles per transaction plus controller latency. After completion, the next grant is decided in IDLE the following cycle, so there is at least one IDLE cycle between transactions.
- Request arriving during ISSUE/WAIT: stays pending and is served next, under the tie rules.
- Completion and a new toggle from the other port in the same cycle: the new request is granted on the next IDLE cycle; nothing is lost.
- Reset mid-transaction: returns to IDLE immediately and clears all toggles. A late sdr_ack is ignored because the controller is reset by the same reset.
- A controller ack received outside WAIT is ignored.

## Structure
- Shared package sound_pkg:
  - arb_state_t {IDLE, ISSUE, WAIT}.
  - gnt_t {GNT_CPU, GNT_SMP}.
  - SDR_ADDR_W = 25.
- Single module; no sub-module. The 64→16 word select is a local function.

## Test plan
- CPU read only: cpu_addr=0x0A0004, cpu_wr_sel=00, cpu_req 0→1; controller acks after 5 cycles with sdr_dout=0x4444_3333_2222_1111 → sdr_addr=0x0A0004, cpu_dout=0x3333, cpu_ack=1, smp_ack unchanged.
- CPU write: cpu_wr_sel=10, cpu_din=0xAB00 → sdr_wr_sel=10, sdr_din=0xAB00, cpu_ack toggles, cpu_dout unchanged.
- Tie, CPU_PRIO=0: both toggle in the same cycle, repeated 4 times → grants alternate CPU, SMP, CPU, SMP. With CPU_PRIO=1 → CPU, CPU, ... while the CPU stays pending.
- Sample read: smp_addr=0x100008, controller returns 0x0123_4567_89AB_CDEF → smp_data matches, sdr_wr_sel=00, smp_ack toggles exactly once.
- Mid-flight input change: alter cpu_addr/cpu_din during WAIT → sdr_addr and sdr_din keep their latched values.
- Reset asserted in WAIT → all outputs 0 asynchronously, busy=0. A subsequent request completes normally.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types for the sound-subsystem SDRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sound_pkg;

  localparam int SDR_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_SMP = 1'b1
  } gnt_t;

endpackage

// File: rtl/sound_sdr_arbiter.sv
// Shares one SDRAM controller channel between the sound CPU port and the GA20 sample port.
// Latency: request seen in IDLE, sdr_req toggles one cycle later; requester ack one cycle after sdr_ack.
// Backpressure: toggle handshakes; a pending request waits in place until the channel returns to IDLE.
module sound_sdr_arbiter
  import sound_pkg::*;
#(
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [SDR_ADDR_W-1:0] cpu_addr,
  input  logic [15:0]           cpu_din,
  input  logic [1:0]            cpu_wr_sel,
  input  logic                  cpu_req,
  output logic                  cpu_ack,
  output logic [15:0]           cpu_dout,
  input  logic [SDR_ADDR_W-1:0] smp_addr,
  input  logic                  smp_req,
  output logic                  smp_ack,
  output logic [63:0]           smp_data,
  output logic [SDR_ADDR_W-1:0] sdr_addr,
  output logic [15:0]           sdr_din,
  output logic [1:0]            sdr_wr_sel,
  output logic                  sdr_req,
  input  logic                  sdr_ack,
  input  logic [63:0]           sdr_dout,
  output logic                  busy
);

  // Pick the 16-bit lane of a 64-bit controller word addressed by byte-address bits [2:1].
  function automatic logic [15:0] word_sel(input logic [63:0] w, input logic [1:0] idx);
    return w[{idx, 4'b0000} +: 16];
  endfunction

  arb_state_t            state;
  gnt_t                  gnt;
  gnt_t                  last_gnt;
  gnt_t                  next_gnt;
  logic [SDR_ADDR_W-1:0] lat_addr;
  logic [15:0]           lat_din;
  logic [1:0]            lat_wr_sel;
  logic                  cpu_pend;
  logic                  smp_pend;

  // Pending detection and grant choice; ties go to the CPU in priority mode, otherwise alternate.
  always_comb begin
    cpu_pend = cpu_req ^ cpu_ack;
    smp_pend = smp_req ^ smp_ack;
    next_gnt = GNT_SMP;
    if (cpu_pend && smp_pend) begin
      if (CPU_PRIO || (last_gnt == GNT_SMP)) next_gnt = GNT_CPU;
      else                                   next_gnt = GNT_SMP;
    end else if (cpu_pend) begin
      next_gnt = GNT_CPU;
    end
  end

  // Arbitration FSM: latch the winner in IDLE, issue in ISSUE, return the completion from WAIT.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= GNT_CPU;
      last_gnt   <= GNT_SMP;
      lat_addr   <= '0;
      lat_din    <= '0;
      lat_wr_sel <= '0;
      cpu_ack    <= 1'b0;
      cpu_dout   <= '0;
      smp_ack    <= 1'b0;
      smp_data   <= '0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      sdr_wr_sel <= '0;
      sdr_req    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_pend || smp_pend) begin
            gnt <= next_gnt;
            if (next_gnt == GNT_CPU) begin
              lat_addr   <= cpu_addr;
              lat_din    <= cpu_din;
              lat_wr_sel <= cpu_wr_sel;
            end else begin
              // Sample fetches are always plain reads with no write data.
              lat_addr   <= smp_addr;
              lat_din    <= '0;
              lat_wr_sel <= 2'b00;
            end
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          sdr_addr   <= lat_addr;
          sdr_din    <= lat_din;
          sdr_wr_sel <= lat_wr_sel;
          sdr_req    <= ~sdr_req;
          last_gnt   <= gnt;
          state      <= WAIT;
        end
        WAIT: begin
          if (sdr_ack == sdr_req) begin
            if (gnt == GNT_CPU) begin
              // Writes leave the last read value in place.
              if (lat_wr_sel == 2'b00) cpu_dout <= word_sel(sdr_dout, lat_addr[2:1]);
              cpu_ack <= ~cpu_ack;
            end else begin
              smp_data <= sdr_dout;
              smp_ack  <= ~smp_ack;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
